// File: rtl/divider_pkg.sv
// Shared width and FSM state definitions for the 16-by-8 sequential divider.
package divider_pkg;

   localparam int DW    = 8;
   localparam int CNT_W = $clog2(DW);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/divider_seq_ctrl_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational; no handshake.
module div_step
   import divider_pkg::*;
(
   input  logic [DW:0]   pr_i,
   input  logic          bit_i,
   input  logic [DW-1:0] divisor_i,
   output logic [DW:0]   pr_o,
   output logic          qbit_o
);

   logic [DW:0] t;
   // pr < divisor after every step, so its top bit never carries into t.
   logic        unused_pr_msb;

   assign unused_pr_msb = pr_i[DW];

   always_comb begin
      t = {pr_i[DW-1:0], bit_i};
      if (t >= {1'b0, divisor_i}) begin
         pr_o   = t - {1'b0, divisor_i};
         qbit_o = 1'b1;
      end else begin
         pr_o   = t;
         qbit_o = 1'b0;
      end
   end

endmodule

// File: rtl/divider_seq_ctrl.sv
// Sequential 16/8 restoring divider: VALID 2+DW cycles after START (2 on DZ/DO), one bit per clock.
// No backpressure: START is only sampled in IDLE, results hold until the next VALID strobe.
module divider_seq_ctrl
   import divider_pkg::*;
(
   input  logic            CLK,
   input  logic            I_RST,
   input  logic            START,
   input  logic [2*DW-1:0] DIVIDEND,
   input  logic [DW-1:0]   DIVISOR,
   output logic            BUSY,
   output logic            VALID,
   output logic [DW-1:0]   QUOTIENT,
   output logic [DW-1:0]   REMAINDER,
   output logic            DZ,
   output logic            DO
);

   state_t            state_q,    state_d;
   logic [2*DW-1:0]   dividend_q, dividend_d;
   logic [DW-1:0]     divisor_q,  divisor_d;
   logic [DW:0]       pr_q,       pr_d;
   logic [DW-1:0]     sr_q,       sr_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   logic [DW-1:0]     quo_q,      quo_d;
   logic [DW-1:0]     rem_q,      rem_d;
   logic              dz_q,       dz_d;
   logic              do_q,       do_d;
   logic              busy_q,     busy_d;
   logic              valid_q,    valid_d;

   logic [DW:0]       step_pr;
   logic              step_qbit;

   div_step u_div_step (
      .pr_i      (pr_q),
      .bit_i     (sr_q[DW-1]),
      .divisor_i (divisor_q),
      .pr_o      (step_pr),
      .qbit_o    (step_qbit)
   );

   always_comb begin
      state_d    = state_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      pr_d       = pr_q;
      sr_d       = sr_q;
      cnt_d      = cnt_q;
      quo_d      = quo_q;
      rem_d      = rem_q;
      dz_d       = dz_q;
      do_d       = do_q;

      case (state_q)
         S_IDLE: begin
            if (START) begin
               dividend_d = DIVIDEND;
               divisor_d  = DIVISOR;
               state_d    = S_CHECK;
            end
         end
         S_CHECK: begin
            // Result registers are loaded on the edge into DONE so they change with VALID.
            if (divisor_q == '0) begin
               dz_d    = 1'b1;
               do_d    = 1'b0;
               quo_d   = '0;
               rem_d   = '0;
               state_d = S_DONE;
            end else if (dividend_q[2*DW-1:DW] >= divisor_q) begin
               dz_d    = 1'b0;
               do_d    = 1'b1;
               quo_d   = '0;
               rem_d   = '0;
               state_d = S_DONE;
            end else begin
               pr_d    = {1'b0, dividend_q[2*DW-1:DW]};
               sr_d    = dividend_q[DW-1:0];
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            pr_d  = step_pr;
            sr_d  = {sr_q[DW-2:0], step_qbit};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DW - 1)) begin
               quo_d   = {sr_q[DW-2:0], step_qbit};
               rem_d   = step_pr[DW-1:0];
               dz_d    = 1'b0;
               do_d    = 1'b0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      valid_d = (state_d == S_DONE);
      busy_d  = (state_d == S_CHECK) || (state_d == S_RUN);
   end

   always_ff @(posedge CLK) begin
      if (I_RST) begin
         state_q    <= S_IDLE;
         dividend_q <= '0;
         divisor_q  <= '0;
         pr_q       <= '0;
         sr_q       <= '0;
         cnt_q      <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
         dz_q       <= 1'b0;
         do_q       <= 1'b0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         pr_q       <= pr_d;
         sr_q       <= sr_d;
         cnt_q      <= cnt_d;
         quo_q      <= quo_d;
         rem_q      <= rem_d;
         dz_q       <= dz_d;
         do_q       <= do_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
      end
   end

   assign BUSY      = busy_q;
   assign VALID     = valid_q;
   assign QUOTIENT  = quo_q;
   assign REMAINDER = rem_q;
   assign DZ        = dz_q;
   assign DO        = do_q;

endmodule

// File: tb/tb_divider_seq_ctrl.sv
// Scoreboard bench for divider_seq_ctrl: directed cases, reset/ignore cases, random sweep.
module tb_divider_seq_ctrl;
   import divider_pkg::*;

   logic            CLK = 1'b0;
   logic            I_RST;
   logic            START;
   logic [2*DW-1:0] DIVIDEND;
   logic [DW-1:0]   DIVISOR;
   logic            BUSY;
   logic            VALID;
   logic [DW-1:0]   QUOTIENT;
   logic [DW-1:0]   REMAINDER;
   logic            DZ;
   logic            DO;

   divider_seq_ctrl dut (
      .CLK       (CLK),
      .I_RST     (I_RST),
      .START     (START),
      .DIVIDEND  (DIVIDEND),
      .DIVISOR   (DIVISOR),
      .BUSY      (BUSY),
      .VALID     (VALID),
      .QUOTIENT  (QUOTIENT),
      .REMAINDER (REMAINDER),
      .DZ        (DZ),
      .DO        (DO)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
      logic       dov;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];

   function automatic exp_t model(input logic [15:0] a, input logic [7:0] b, input int cy);
      exp_t e;
      e.q   = 8'd0;
      e.r   = 8'd0;
      e.dz  = 1'b0;
      e.dov = 1'b0;
      if (b == 8'd0) begin
         e.dz  = 1'b1;
         e.cyc = cy + 2;
      end else if (a[15:8] >= b) begin
         e.dov = 1'b1;
         e.cyc = cy + 2;
      end else begin
         e.q   = 8'(a / {8'd0, b});
         e.r   = 8'(a % {8'd0, b});
         e.cyc = cy + 2 + DW;
      end
      return e;
   endfunction

   // Scoreboard consumer: every VALID must match the oldest outstanding expectation.
   always @(negedge CLK) begin
      exp_t e;
      if (!I_RST && VALID) begin
         if (exp_q.size() == 0) begin
            chk("spurious_valid", 32'(VALID), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("quotient",    32'(QUOTIENT),  32'(e.q));
            chk("remainder",   32'(REMAINDER), 32'(e.r));
            chk("dz",          32'(DZ),        32'(e.dz));
            chk("do",          32'(DO),        32'(e.dov));
            chk("valid_cycle", 32'(cyc),       32'(e.cyc));
         end
      end
   end

   // Called at a negedge with the DUT idle; START is seen by exactly one edge.
   task automatic issue_exp(input logic [15:0] a, input logic [7:0] b,
                            input logic [7:0] q, input logic [7:0] r,
                            input logic dz, input logic dov, input int lat);
      exp_t e;
      e.q = q; e.r = r; e.dz = dz; e.dov = dov; e.cyc = cyc + lat;
      exp_q.push_back(e);
      DIVIDEND = a;
      DIVISOR  = b;
      START    = 1'b1;
      @(negedge CLK);
      START    = 1'b0;
   endtask

   task automatic issue_rand(input logic [15:0] a, input logic [7:0] b);
      exp_q.push_back(model(a, b, cyc));
      DIVIDEND = a;
      DIVISOR  = b;
      START    = 1'b1;
      @(negedge CLK);
      START    = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (exp_q.size() == 0) break;
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
      @(negedge CLK);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},  32'(BUSY),      32'd0);
      chk({tag, "_valid"}, 32'(VALID),     32'd0);
      chk({tag, "_q"},     32'(QUOTIENT),  32'd0);
      chk({tag, "_r"},     32'(REMAINDER), 32'd0);
      chk({tag, "_dz"},    32'(DZ),        32'd0);
      chk({tag, "_do"},    32'(DO),        32'd0);
   endtask

   initial begin
      #3000000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c0;
      logic [7:0]  b;
      logic [7:0]  hi;
      logic [15:0] a;

      I_RST    = 1'b1;
      START    = 1'b0;
      DIVIDEND = '0;
      DIVISOR  = '0;
      repeat (3) @(negedge CLK);
      chk_all_zero("reset");
      I_RST = 1'b0;
      @(negedge CLK);

      // 1000/7 with BUSY profile across the operation.
      c0 = cyc;
      issue_exp(16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 1'b0, 10);
      for (int k = 1; k <= 9; k++) begin
         chk("busy_run", 32'(BUSY), 32'd1);
         @(negedge CLK);
      end
      chk("busy_done", 32'(BUSY), 32'd0);
      chk("busy_cycle", 32'(cyc), 32'(c0 + 10));
      drain("drain_t1");
      chk("q_hold", 32'(QUOTIENT), 32'h8E);

      // Headroom case: partial remainder reaches 2*divisor-1.
      issue_exp(16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0, 10);
      drain("drain_t2");

      // Divide by zero, then overflow with hi byte equal to divisor.
      issue_exp(16'h1234, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2);
      drain("drain_t3a");
      chk("dz_hold", 32'(DZ), 32'd1);
      issue_exp(16'h1234, 8'h12, 8'h00, 8'h00, 1'b0, 1'b1, 2);
      drain("drain_t3b");

      // A START pulse mid-RUN must be dropped, not queued.
      issue_exp(16'h03E8, 8'h07, 8'h8E, 8'h06, 1'b0, 1'b0, 10);
      @(negedge CLK);
      @(negedge CLK);
      DIVIDEND = 16'h0010;
      DIVISOR  = 8'h02;
      START    = 1'b1;
      @(negedge CLK);
      START    = 1'b0;
      drain("drain_t4a");
      repeat (12) @(negedge CLK);
      issue_exp(16'h0010, 8'h02, 8'h08, 8'h00, 1'b0, 1'b0, 10);
      drain("drain_t4b");

      // Reset mid-RUN discards the operation with no VALID.
      DIVIDEND = 16'h03E8;
      DIVISOR  = 8'h07;
      START    = 1'b1;
      @(negedge CLK);
      START    = 1'b0;
      repeat (3) @(negedge CLK);
      I_RST = 1'b1;
      @(negedge CLK);
      chk_all_zero("midrun_reset");
      I_RST = 1'b0;
      repeat (14) @(negedge CLK);
      chk("no_valid_after_reset", 32'(exp_q.size()), 32'd0);
      issue_exp(16'h0064, 8'h0A, 8'h0A, 8'h00, 1'b0, 1'b0, 10);
      drain("drain_t5");

      // START held high: second accept follows DONE by one IDLE cycle.
      exp_q.push_back(model(16'h03E8, 8'h07, cyc));
      exp_q.push_back(model(16'h03E8, 8'h07, cyc + DW + 3));
      DIVIDEND = 16'h03E8;
      DIVISOR  = 8'h07;
      START    = 1'b1;
      repeat (DW + 4) @(negedge CLK);
      START    = 1'b0;
      drain("drain_b2b");

      // Random sweep, biased so most pairs take the normal path.
      for (int n = 0; n < 2000; n++) begin
         b = 8'($urandom_range(0, 255));
         if (b != 8'd0 && $urandom_range(0, 3) != 0)
            hi = 8'($urandom_range(0, int'(b) - 1));
         else
            hi = 8'($urandom_range(0, 255));
         a = {hi, 8'($urandom_range(0, 255))};
         issue_rand(a, b);
         drain("drain_rand");
      end

      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
